// File: rtl/tempsense_pkg.sv
// tempsense_pkg: shared state encoding and widths for the tempsense conversion sequencer
package tempsense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        CONV,
        CAP,
        EVAL
    } state_e;

    localparam int DoutW = 24;
    localparam int SelW  = 4;

endpackage

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync: two-flop synchroniser bringing an asynchronous level into clk_i
module prim_flop_2sync #(
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta;

    // first flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= '0;
            q_o  <= '0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/tempsense_conv_ctrl.sv
// tempsense_conv_ctrl: sequences tempsense macro conversions, averages samples, raises threshold alerts
module tempsense_conv_ctrl
    import tempsense_pkg::*;
#(
    parameter int RstCycles  = 4,
    parameter int TimeoutW   = 20,
    parameter int AvgMaxLog2 = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic [SelW-1:0]  conv_time_i,
    input  logic [1:0]       avg_log2_i,
    input  logic [DoutW-1:0] thr_hi_i,
    input  logic [DoutW-1:0] thr_lo_i,
    output logic             ts_rst_no,
    output logic             ts_en_o,
    output logic [SelW-1:0]  ts_sel_o,
    input  logic [DoutW-1:0] ts_dout_i,
    input  logic             ts_done_i,
    output logic             busy_o,
    output logic [DoutW-1:0] result_o,
    output logic             result_vld_o,
    output logic             alert_hi_o,
    output logic             alert_lo_o,
    output logic             timeout_o
);

    localparam int AccW = DoutW + AvgMaxLog2;
    localparam int RcW  = RstCycles > 1 ? $clog2(RstCycles) : 1;

    state_e                state;
    logic                  done_s, done_q, done_rise;
    logic [RcW-1:0]        rst_cnt;
    logic [TimeoutW-1:0]   wd_cnt;
    logic [1:0]            avg_q;
    logic [AccW-1:0]       acc, acc_sh;
    logic [AvgMaxLog2:0]   cnt, n_samp;
    logic [DoutW-1:0]      res_new;

    assign acc_sh  = acc >> avg_q;
    assign res_new = acc_sh[DoutW-1:0];
    assign n_samp  = (AvgMaxLog2 + 1)'(1) << avg_q;

    prim_flop_2sync #(.Width(1)) u_done_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (ts_done_i),
        .q_o   (done_s)
    );

    // registered rising-edge detect: a DONE that is already high never counts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q    <= 1'b0;
            done_rise <= 1'b0;
        end else begin
            done_q    <= done_s;
            done_rise <= done_s & ~done_q;
        end
    end

    // conversion sequencer: macro control, watchdog, accumulation, result and alerts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            ts_rst_no    <= 1'b0;
            ts_en_o      <= 1'b0;
            ts_sel_o     <= '0;
            busy_o       <= 1'b0;
            result_o     <= '0;
            result_vld_o <= 1'b0;
            alert_hi_o   <= 1'b0;
            alert_lo_o   <= 1'b0;
            timeout_o    <= 1'b0;
            rst_cnt      <= '0;
            wd_cnt       <= '0;
            avg_q        <= '0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            result_vld_o <= 1'b0;
            if (abort_i) begin
                state     <= IDLE;
                ts_en_o   <= 1'b0;
                ts_rst_no <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        ts_sel_o   <= conv_time_i;
                        avg_q      <= avg_log2_i > 2'(AvgMaxLog2) ? 2'(AvgMaxLog2) : avg_log2_i;
                        acc        <= '0;
                        cnt        <= '0;
                        alert_hi_o <= 1'b0;
                        alert_lo_o <= 1'b0;
                        timeout_o  <= 1'b0;
                        rst_cnt    <= '0;
                        busy_o     <= 1'b1;
                        state      <= RST;
                    end
                    RST: if (rst_cnt == RcW'(RstCycles - 1)) begin
                        ts_rst_no <= 1'b1;
                        ts_en_o   <= 1'b1;
                        wd_cnt    <= TimeoutW'(1);
                        state     <= CONV;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                    CONV: if (done_rise) begin
                        state <= CAP;
                    end else if (&wd_cnt) begin
                        timeout_o <= 1'b1;
                        ts_en_o   <= 1'b0;
                        ts_rst_no <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    CAP: begin
                        acc   <= acc + AccW'(ts_dout_i);
                        cnt   <= cnt + 1'b1;
                        state <= EVAL;
                    end
                    EVAL: begin
                        ts_en_o   <= 1'b0;
                        ts_rst_no <= 1'b0;
                        rst_cnt   <= '0;
                        if (cnt < n_samp) begin
                            state <= RST;
                        end else begin
                            result_o     <= res_new;
                            result_vld_o <= 1'b1;
                            alert_hi_o   <= alert_hi_o | (res_new > thr_hi_i);
                            alert_lo_o   <= alert_lo_o | (res_new < thr_lo_i);
                            if (cont_i) begin
                                acc   <= '0;
                                cnt   <= '0;
                                state <= RST;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tempsense_conv_ctrl.sv
// tb_tempsense_conv_ctrl: directed, table-driven bench for the tempsense conversion sequencer
module tb_tempsense_conv_ctrl;

    localparam int RstCycles = 4;
    localparam int TimeoutW  = 6;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        start_i = 1'b0, cont_i = 1'b0, abort_i = 1'b0;
    logic [3:0]  conv_time_i = '0;
    logic [1:0]  avg_log2_i = '0;
    logic [23:0] thr_hi_i = '0, thr_lo_i = '0;
    logic        ts_rst_no, ts_en_o;
    logic [3:0]  ts_sel_o;
    logic [23:0] ts_dout_i = '0;
    logic        ts_done_i = 1'b0;
    logic        busy_o, result_vld_o, alert_hi_o, alert_lo_o, timeout_o;
    logic [23:0] result_o;

    int total = 0, bad = 0;

    tempsense_conv_ctrl #(.RstCycles(RstCycles), .TimeoutW(TimeoutW), .AvgMaxLog2(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .cont_i(cont_i), .abort_i(abort_i),
        .conv_time_i(conv_time_i), .avg_log2_i(avg_log2_i), .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i),
        .ts_rst_no(ts_rst_no), .ts_en_o(ts_en_o), .ts_sel_o(ts_sel_o), .ts_dout_i(ts_dout_i),
        .ts_done_i(ts_done_i), .busy_o(busy_o), .result_o(result_o), .result_vld_o(result_vld_o),
        .alert_hi_o(alert_hi_o), .alert_lo_o(alert_lo_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // macro model: DONE clears while held in reset, rises conv_dly cycles after enable with the next sample
    logic [7:0][23:0] smp = '0;
    int  sidx = 0, mcnt = 0, conv_dly = 50;
    bit  model_en = 1'b1;
    always @(negedge clk_i) begin
        if (!ts_rst_no) begin
            ts_done_i = 1'b0;
            mcnt = 0;
        end else if (ts_en_o && !ts_done_i && model_en) begin
            mcnt++;
            if (mcnt == conv_dly) begin
                ts_dout_i = smp[sidx % 8];
                ts_done_i = 1'b1;
                sidx++;
            end
        end
    end

    typedef struct packed {
        logic [1:0]       avg;
        logic [7:0][23:0] s;
        logic [23:0]      hi;
        logic [23:0]      lo;
        logic [23:0]      res;
        logic             ah;
        logic             al;
    } vec_t;

    vec_t vt[7];

    function automatic vec_t mk(input logic [1:0] a, input logic [7:0][23:0] s,
                                input logic [23:0] hi, lo, res, input logic ah, al);
        vec_t v;
        v.avg = a; v.s = s; v.hi = hi; v.lo = lo; v.res = res; v.ah = ah; v.al = al;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nvld = 0, nrst = 0;
        bit fin = 1'b0;
        logic [23:0] got = '0;
        smp = v.s; sidx = 0; model_en = 1'b1;
        avg_log2_i = v.avg; thr_hi_i = v.hi; thr_lo_i = v.lo; conv_time_i = 4'(idx + 1);
        pulse_start();
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (busy_o && !ts_rst_no) nrst++;
            if (result_vld_o) begin nvld++; got = result_o; end
            if (!busy_o) fin = 1'b1; else tick();
        end
        chk($sformatf("v%0d_finished", idx), 32'(fin), 1);
        chk($sformatf("v%0d_result", idx), 32'(got), 32'(v.res));
        chk($sformatf("v%0d_vld_count", idx), nvld, 1);
        chk($sformatf("v%0d_rst_low", idx), nrst, RstCycles << v.avg);
        chk($sformatf("v%0d_alerts", idx), {alert_hi_o, alert_lo_o, timeout_o}, {v.ah, v.al, 1'b0});
        chk($sformatf("v%0d_sel", idx), 32'(ts_sel_o), idx + 1);
        tick();
    endtask

    initial begin
        int n;
        bit fin;
        logic [23:0] r0, r1;
        vt[0] = mk(0, {168'd0, 24'h00ABCD}, 24'hFFFFFF, 24'h0, 24'h00ABCD, 0, 0);
        vt[1] = mk(2, {96'd0, 24'd41, 24'd30, 24'd20, 24'd10}, 24'hFFFFFF, 24'h0, 24'd25, 0, 0);
        vt[2] = mk(0, {168'd0, 24'd101}, 24'd100, 24'd50, 24'd101, 1, 0);
        vt[3] = mk(0, {168'd0, 24'd100}, 24'd100, 24'd50, 24'd100, 0, 0);
        vt[4] = mk(0, {168'd0, 24'd49}, 24'd100, 24'd50, 24'd49, 0, 1);
        vt[5] = mk(1, {144'd0, 24'hFFFFFF, 24'hFFFFFF}, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0, 0);
        vt[6] = mk(3, {24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1}, 24'd3, 24'd5, 24'd4, 1, 1);

        repeat (3) tick();
        chk("reset_outputs", {ts_rst_no, ts_en_o, busy_o, result_vld_o, alert_hi_o, alert_lo_o, timeout_o}, 0);
        chk("reset_result", 32'(result_o), 0);
        chk("reset_sel", 32'(ts_sel_o), 0);
        rst_ni = 1'b1;
        tick();

        // watchdog: DONE never rises
        model_en = 1'b0; avg_log2_i = 0;
        pulse_start();
        n = 0; fin = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            if (result_vld_o) chk("timeout_no_vld", 1, 0);
            if (busy_o && ts_en_o && ts_rst_no) n++;
            if (!busy_o) fin = 1'b1; else tick();
        end
        chk("timeout_finished", 32'(fin), 1);
        chk("timeout_conv_cycles", n, 63);
        chk("timeout_flag", {timeout_o, ts_en_o, ts_rst_no}, 3'b100);
        tick();

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // start and abort together in IDLE: abort wins
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("start_abort_idle", {busy_o, ts_rst_no, ts_en_o}, 0);
        tick();

        // continuous mode: back-to-back results, then abort mid-conversion
        smp = {120'd0, 24'd9, 24'd8, 24'd7}; sidx = 0; model_en = 1'b1;
        avg_log2_i = 0; thr_hi_i = 24'hFFFFFF; thr_lo_i = 0; cont_i = 1'b1;
        pulse_start();
        n = 0; r0 = '0; r1 = '0;
        for (int c = 0; c < 1000 && n < 2; c++) begin
            if (result_vld_o) begin
                if (n == 0) r0 = result_o; else r1 = result_o;
                n++;
            end
            if (n < 2) tick();
        end
        chk("cont_vld_count", n, 2);
        chk("cont_results", {r0, r1}, {24'd7, 24'd8});
        chk("cont_still_busy", 32'(busy_o), 1);
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (ts_en_o) fin = 1'b1; else tick();
        end
        chk("cont_rearm_conv", 32'(fin), 1);
        repeat (5) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_idle", {busy_o, ts_en_o, ts_rst_no, result_vld_o}, 0);
        chk("abort_result_kept", 32'(result_o), 8);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (result_vld_o || busy_o) n++;
            tick();
        end
        chk("abort_quiet", n, 0);
        cont_i = 1'b0;

        // async reset mid-conversion
        pulse_start();
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (ts_en_o) fin = 1'b1; else tick();
        end
        chk("rst_reached_conv", 32'(fin), 1);
        repeat (5) tick();
        rst_ni = 1'b0;
        #1;
        chk("async_reset", {ts_en_o, busy_o, ts_rst_no}, 0);
        chk("async_reset_result", 32'(result_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
